// File: rtl/mem_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_arbiter_pkg
// Purpose  : Shared types and constants for the memory access arbiter:
//            controller state encoding, cell operation codes and a
//            modulo-N pointer increment helper.
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_HOLD    = 2'b10,
    ST_RECOVER = 2'b11
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Next round-robin position after idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_arbiter_rr_arbiter
// Purpose  : Combinational round-robin pick (the rr_arbiter). Returns the
//            first requester at or after i_ptr, wrapping modulo N_REQ.
// Ports    : i_req    - request vector
//            i_ptr    - starting search position
//            o_onehot - one-hot winner (zero when no request)
//            o_idx    - index of the winner
//            o_valid  - at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_arbiter_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  always_comb begin
    int w_pos;
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_pos    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_pos = int'(i_ptr) + i;
      if (w_pos >= N_REQ) w_pos = w_pos - N_REQ;
      // First hit in search order wins; later hits are ignored.
      if (!o_valid && i_req[w_pos]) begin
        o_valid         = 1'b1;
        o_idx           = IDX_W'(w_pos);
        o_onehot[w_pos] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_arbiter
// Purpose  : Shares one memory cell access FSM between N_REQ requesters.
//            Round-robin grant, drive select/op/addr, wait for the matching
//            valid/rw, hold a settle window, then return done (and err on
//            timeout) to the granted requester.
// Ports    : clk, rst                    - clock, async active-high reset
//            i_req/i_req_op/i_req_addr   - requester side (level requests)
//            o_gnt/o_done/o_err          - grant, completion, timeout flag
//            o_mem_select/o_mem_op/o_mem_addr - to the cell FSM
//            i_mem_valid/i_mem_rw        - cell FSM state bits
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ADDR_W      = 6,
  parameter int HOLD_CYCLES = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ-1:0]        i_req_op,
  input  logic [N_REQ*ADDR_W-1:0] i_req_addr,
  output logic [N_REQ-1:0]        o_gnt,
  output logic [N_REQ-1:0]        o_done,
  output logic                    o_err,
  output logic                    o_mem_select,
  output logic                    o_mem_op,
  output logic [ADDR_W-1:0]       o_mem_addr,
  input  logic                    i_mem_valid,
  input  logic                    i_mem_rw
);

  localparam int c_IDX_W  = $clog2(N_REQ);
  localparam int c_TCNT_W = $clog2(TIMEOUT);
  localparam int c_HCNT_W = $clog2(HOLD_CYCLES + 1);

  state_t              r_state;
  logic [c_IDX_W-1:0]  r_ptr;
  logic [c_IDX_W-1:0]  r_idx;
  logic [c_TCNT_W-1:0] r_tcnt;
  logic [c_HCNT_W-1:0] r_hcnt;
  logic [N_REQ-1:0]    r_gnt;
  logic [N_REQ-1:0]    r_done;
  logic                r_err;
  logic                r_sel;
  logic                r_op;
  logic [ADDR_W-1:0]   r_addr;

  logic [N_REQ-1:0]    w_onehot;
  logic [c_IDX_W-1:0]  w_idx;
  logic                w_any;
  logic                w_match;
  logic                w_tmo;
  logic [c_IDX_W-1:0]  w_ptr_next;

  mem_access_arbiter_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (c_IDX_W)
  ) u_rr (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_valid  (w_any)
  );

  // The cell reports rw=1 in its Write state and rw=0 in Read.
  assign w_match    = i_mem_valid && (i_mem_rw == ((r_op == OP_WRITE) ? 1'b1 : 1'b0));
  // One counter serves both ISSUE and RECOVER; it is cleared on entry.
  assign w_tmo      = (r_tcnt == c_TCNT_W'(TIMEOUT - 1));
  assign w_ptr_next = c_IDX_W'(wrap_inc(int'(r_idx), N_REQ));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_tcnt  <= '0;
      r_hcnt  <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_sel   <= 1'b0;
      r_op    <= OP_READ;
      r_addr  <= '0;
    end else begin
      // done/err are single-cycle pulses.
      r_done <= '0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_onehot;
            r_idx   <= w_idx;
            r_sel   <= 1'b1;
            r_op    <= i_req_op[w_idx];
            r_addr  <= i_req_addr[w_idx*ADDR_W +: ADDR_W];
            r_tcnt  <= '0;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // A match on the last allowed cycle still counts as success.
          if (w_match) begin
            r_sel   <= 1'b0;
            r_hcnt  <= '0;
            r_state <= ST_HOLD;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_done  <= r_gnt;
            r_gnt   <= '0;
            r_sel   <= 1'b0;
            r_tcnt  <= '0;
            r_state <= ST_RECOVER;
          end else begin
            r_tcnt <= r_tcnt + c_TCNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (r_hcnt == c_HCNT_W'(HOLD_CYCLES - 1)) begin
            r_done  <= r_gnt;
            r_gnt   <= '0;
            r_tcnt  <= '0;
            r_state <= ST_RECOVER;
          end else begin
            r_hcnt <= r_hcnt + c_HCNT_W'(1);
          end
        end
        ST_RECOVER: begin
          if (!i_mem_valid) begin
            r_ptr   <= w_ptr_next;
            r_state <= ST_IDLE;
          end else if (w_tmo) begin
            // Cell never returned to Idle: flag it, but no second done.
            r_err   <= 1'b1;
            r_ptr   <= w_ptr_next;
            r_state <= ST_IDLE;
          end else begin
            r_tcnt <= r_tcnt + c_TCNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_gnt        = r_gnt;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_mem_select = r_sel;
  assign o_mem_op     = r_op;
  assign o_mem_addr   = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_arbiter
// Purpose  : Self-checking bench for mem_access_arbiter. A transaction-level
//            model predicts winner, captured op/addr and the cycle on which
//            select drops, done/err pulse and the grant is released.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_arbiter;

  localparam int N       = 4;
  localparam int AW      = 6;
  localparam int HOLD    = 2;
  localparam int TMO     = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  i_req = '0;
  logic [N-1:0]  i_req_op = '0;
  logic [N*AW-1:0] i_req_addr = '0;
  logic [N-1:0]  o_gnt;
  logic [N-1:0]  o_done;
  logic          o_err;
  logic          o_mem_select;
  logic          o_mem_op;
  logic [AW-1:0] o_mem_addr;
  logic          i_mem_valid = 1'b0;
  logic          i_mem_rw = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int m_ptr = 0;

  always #5 clk = ~clk;

  mem_access_arbiter #(
    .N_REQ (N), .ADDR_W (AW), .HOLD_CYCLES (HOLD), .TIMEOUT (TMO)
  ) dut (
    .clk (clk), .rst (rst),
    .i_req (i_req), .i_req_op (i_req_op), .i_req_addr (i_req_addr),
    .o_gnt (o_gnt), .o_done (o_done), .o_err (o_err),
    .o_mem_select (o_mem_select), .o_mem_op (o_mem_op), .o_mem_addr (o_mem_addr),
    .i_mem_valid (i_mem_valid), .i_mem_rw (i_mem_rw)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First set bit at or after p, wrapping.
  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++)
      if (m[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req = '0; i_mem_valid = 1'b0;
    tick(); tick();
    #2 rst = 1'b0;
    m_ptr = 0;
  endtask

  // One full access starting with the DUT in IDLE and i_req nonzero.
  // rdly : ISSUE cycle index at which the cell starts reporting valid
  // rrw  : rw value the cell reports
  // vdrop: RECOVER cycle index at which the cell drops valid
  // drop : release the winner's request right after grant
  task automatic run_access(input int rdly, input logic rrw, input int vdrop,
                            input bit drop, input string tag);
    int w, n_issue, n_rec;
    logic [N-1:0] oh;
    logic eop;
    logic [AW-1:0] eaddr;
    bit succ;
    w = pick(i_req, m_ptr);
    oh = 4'b0001 << w;
    eop = i_req_op[w];
    eaddr = i_req_addr[w*AW +: AW];
    i_mem_valid = 1'b0; i_mem_rw = 1'b0;
    tick();
    chk({tag, ".gnt"},  32'(o_gnt), 32'(oh));
    chk({tag, ".sel"},  32'(o_mem_select), 32'd1);
    chk({tag, ".op"},   32'(o_mem_op), 32'(eop));
    chk({tag, ".addr"}, 32'(o_mem_addr), 32'(eaddr));
    chk({tag, ".done0"}, 32'(o_done), 32'd0);
    if (drop) i_req[w] = 1'b0;
    i_req_op = 4'($urandom);
    i_req_addr = 24'($urandom);
    succ = (rrw == eop) && (rdly <= TMO - 1);
    n_issue = succ ? rdly + 1 : TMO;
    for (int k = 0; k < n_issue; k++) begin
      i_mem_valid = (k >= rdly); i_mem_rw = rrw;
      tick();
      if (k < n_issue - 1) begin
        chk({tag, ".iss_sel"},  32'(o_mem_select), 32'd1);
        chk({tag, ".iss_gnt"},  32'(o_gnt), 32'(oh));
        chk({tag, ".iss_err"},  32'(o_err), 32'd0);
        chk({tag, ".iss_addr"}, 32'(o_mem_addr), 32'(eaddr));
      end
    end
    if (succ) begin
      chk({tag, ".hold_sel"}, 32'(o_mem_select), 32'd0);
      chk({tag, ".hold_gnt"}, 32'(o_gnt), 32'(oh));
      chk({tag, ".hold_done"}, 32'(o_done), 32'd0);
      for (int h = 0; h < HOLD; h++) begin
        tick();
        if (h < HOLD - 1) begin
          chk({tag, ".hold_done"}, 32'(o_done), 32'd0);
          chk({tag, ".hold_gnt"},  32'(o_gnt), 32'(oh));
        end
      end
      chk({tag, ".done"},  32'(o_done), 32'(oh));
      chk({tag, ".err"},   32'(o_err), 32'd0);
      chk({tag, ".gnt_rel"}, 32'(o_gnt), 32'd0);
    end else begin
      chk({tag, ".tdone"}, 32'(o_done), 32'(oh));
      chk({tag, ".terr"},  32'(o_err), 32'd1);
      chk({tag, ".tgnt"},  32'(o_gnt), 32'd0);
      chk({tag, ".tsel"},  32'(o_mem_select), 32'd0);
    end
    n_rec = (vdrop <= TMO - 1) ? vdrop + 1 : TMO;
    for (int j = 0; j < n_rec; j++) begin
      i_mem_valid = (j < vdrop);
      tick();
      chk({tag, ".rec_done"}, 32'(o_done), 32'd0);
      chk({tag, ".rec_gnt"},  32'(o_gnt), 32'd0);
      chk({tag, ".rec_err"},  32'(o_err),
          32'((j == n_rec - 1) && (vdrop > TMO - 1)));
    end
    i_mem_valid = 1'b0;
    m_ptr = (w + 1) % N;
  endtask

  initial begin
    int w;
    logic rrw;
    // Reset values
    #1;
    chk("rst.gnt",  32'(o_gnt), 32'd0);
    chk("rst.done", 32'(o_done), 32'd0);
    chk("rst.err",  32'(o_err), 32'd0);
    chk("rst.sel",  32'(o_mem_select), 32'd0);
    chk("rst.op",   32'(o_mem_op), 32'd0);
    chk("rst.addr", 32'(o_mem_addr), 32'd0);
    do_reset();

    // Idle with no requests
    tick(); tick();
    chk("idle.gnt", 32'(o_gnt), 32'd0);
    chk("idle.sel", 32'(o_mem_select), 32'd0);

    // Single write to 0x2A
    i_req = 4'b0001; i_req_op = 4'b0001; i_req_addr = 24'h00002A;
    run_access(2, 1'b1, 1, 1'b0, "wr");
    i_req = '0;

    // Round-robin contention, order 0,1,2,3,0
    do_reset();
    i_req = 4'b1111;
    for (int a = 0; a < 5; a++) begin
      i_req_op = 4'($urandom); i_req_addr = 24'($urandom);
      w = pick(i_req, m_ptr);
      chk("rr.order", 32'(w), 32'(a % N));
      run_access(int'($urandom_range(0, 4)), i_req_op[w], int'($urandom_range(0, 3)), 1'b0, "rr");
      i_req = 4'b1111;
    end
    i_req = '0;
    tick();

    // Read request answered as write -> ISSUE timeout with err+done
    i_req = 4'b0010; i_req_op = 4'b0000;
    run_access(0, 1'b1, 0, 1'b0, "wrong");
    // Match arriving one cycle too late also times out
    i_req = 4'b0010; i_req_op = 4'b0010;
    run_access(15, 1'b1, 0, 1'b0, "late");
    // RECOVER timeout: valid never drops
    i_req = 4'b0001; i_req_op = 4'b0000;
    run_access(1, 1'b0, 20, 1'b0, "rectmo");
    i_req = '0;
    tick();
    chk("rectmo.idle_gnt", 32'(o_gnt), 32'd0);

    // Request dropped during ISSUE still completes
    i_req = 4'b0100; i_req_op = 4'b0100;
    run_access(1, 1'b1, 0, 1'b1, "drop");
    i_req = '0;

    // Async reset during HOLD
    tick();
    i_req = 4'b0100; i_req_op = 4'b0100; i_req_addr = 24'($urandom);
    tick();
    chk("rsth.gnt", 32'(o_gnt), 32'b0100);
    i_mem_valid = 1'b1; i_mem_rw = 1'b1;
    tick();
    chk("rsth.sel_hold", 32'(o_mem_select), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rsth.gnt0",  32'(o_gnt), 32'd0);
    chk("rsth.done0", 32'(o_done), 32'd0);
    chk("rsth.err0",  32'(o_err), 32'd0);
    chk("rsth.sel0",  32'(o_mem_select), 32'd0);
    chk("rsth.addr0", 32'(o_mem_addr), 32'd0);
    @(posedge clk); #3;
    rst = 1'b0; i_req = '0; i_mem_valid = 1'b0; m_ptr = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rsth.nodone", 32'(o_done), 32'd0);
      chk("rsth.nognt",  32'(o_gnt), 32'd0);
    end
    i_req = 4'b0101; i_req_op = 4'($urandom);
    chk("rsth.next0", 32'(pick(i_req, m_ptr)), 32'd0);
    run_access(0, i_req_op[0], 0, 1'b0, "rsth");
    i_req = '0;

    // Match on exactly the last ISSUE cycle -> success
    i_req = 4'b1000; i_req_op = 4'b1000;
    run_access(14, 1'b1, 0, 1'b0, "coin");
    i_req = '0;

    // Randomized accesses
    for (int t = 0; t < 25; t++) begin
      i_req = 4'($urandom_range(1, 15));
      i_req_op = 4'($urandom); i_req_addr = 24'($urandom);
      w = pick(i_req, m_ptr);
      rrw = ($urandom_range(0, 3) == 0) ? ~i_req_op[w] : i_req_op[w];
      run_access(int'($urandom_range(0, 16)), rrw, int'($urandom_range(0, 16)),
                 ($urandom_range(0, 3) == 0), "rnd");
      if ($urandom_range(0, 1) == 0) begin
        i_req = '0;
        tick();
        chk("rnd.idle_gnt", 32'(o_gnt), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
